// File: rtl/addsub_nibble_seq_pkg.sv
// Shared constants for the nibble-serial add/subtract controller.
package addsub_nibble_seq_pkg;

  localparam int unsigned SliceW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_nibble_seq_slice4.sv
// 4-bit ripple add/subtract slice; B is inverted by sel, the +1 arrives through cin.
module addsub_slice4
  import addsub_nibble_seq_pkg::*;
(
  input  logic [SliceW-1:0] a4,
  input  logic [SliceW-1:0] b4,
  input  logic              sel,
  input  logic              cin,
  output logic [SliceW-1:0] s4,
  output logic              cout,
  output logic              v
);

  logic [SliceW-1:0] bx;
  logic [SliceW-1:0] low;
  logic              c3;

  always_comb begin
    bx   = b4 ^ {SliceW{sel}};
    low  = {1'b0, a4[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    c3   = low[3];
    s4   = {a4[3] ^ bx[3] ^ c3, low[2:0]};
    cout = (a4[3] & bx[3]) | (c3 & (a4[3] ^ bx[3]));
    // Overflow: carry into the MSB disagrees with carry out of it.
    v    = c3 ^ cout;
  end

endmodule

// File: rtl/addsub_nibble_seq.sv
// W-bit add/subtract computed LSB nibble first over NIBBLES cycles with one shared 4-bit slice.
module addsub_nibble_seq
  import addsub_nibble_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sel,
  input  logic [SliceW*NIBBLES-1:0] a,
  input  logic [SliceW*NIBBLES-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [SliceW*NIBBLES-1:0] s,
  output logic                      cout,
  output logic                      v
);

  localparam int unsigned W    = SliceW * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sel_q, sel_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            v_q, v_d;

  int unsigned       nib_lo;
  logic [SliceW-1:0] sl_a, sl_b, sl_s;
  logic              sl_cout, sl_v;

  always_comb begin
    nib_lo = 32'(idx_q) * SliceW;
    sl_a   = a_q[nib_lo +: SliceW];
    sl_b   = b_q[nib_lo +: SliceW];
  end

  addsub_slice4 u_slice (
    .a4   (sl_a),
    .b4   (sl_b),
    .sel  (sel_q),
    .cin  (carry_q),
    .s4   (sl_s),
    .cout (sl_cout),
    .v    (sl_v)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          idx_d   = '0;
          carry_d = sel;  // two's-complement +1 enters once, at nibble 0
          state_d = StRun;
        end
      end
      StRun: begin
        s_d[nib_lo +: SliceW] = sl_s;
        carry_d = sl_cout;
        if (idx_q == LastIdx) begin
          cout_d  = sl_cout;
          v_d     = sl_v;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign cout = cout_q;
  assign v    = v_q;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed bench for addsub_nibble_seq with NIBBLES=4 (16-bit operands).
module tb_addsub_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, v;
  logic [15:0] s;

  int n_cmp = 0;
  int n_fail = 0;

  addsub_nibble_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .v     (v)
  );

  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for done; no checking here.
  // lat = posedges after the start edge before done is seen; busy_cnt = cycles with busy=1.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tsel,
                        input logic hold_start, output int lat, output int busy_cnt,
                        output logic timed_out);
    int n;
    @(negedge clk);
    a = ta; b = tb_; sel = tsel; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    a = 16'h1111; b = 16'h2222; sel = ~tsel;
    busy_cnt = 0; timed_out = 1'b1; lat = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) begin
        timed_out = 1'b0;
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({busy, done, cout, v} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, cout, v}); end
    n_cmp++; if (s !== 16'h0000) begin
      n_fail++; $display("FAIL reset_s: got %h want 0000", s); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 00", {busy, done}); end
  endtask

  task automatic test_add();
    int lat, bc; logic to;
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, bc, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL add_timeout: got %b want 0", to); end
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_cmp++; if (bc !== 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want 4", bc); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    n_cmp++; if ({s, cout, v} !== {16'h2233, 2'b00}) begin
      n_fail++; $display("FAIL add_result: got s=%h c=%b v=%b want s=2233 c=0 v=0", s, cout, v); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL add_done_pulse: got busy,done=%b want 00", {busy, done}); end
    n_cmp++; if (s !== 16'h2233) begin n_fail++; $display("FAIL add_s_held: got %h want 2233", s); end
  endtask

  task automatic test_sub();
    int lat, bc; logic to;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat, bc, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL sub_timeout: got %b want 0", to); end
    n_cmp++; if ({s, cout, v} !== {16'hFFFE, 2'b00}) begin
      n_fail++; $display("FAIL sub_result: got s=%h c=%b v=%b want s=fffe c=0 v=0", s, cout, v); end
  endtask

  task automatic test_overflow();
    int lat, bc; logic to;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc, to);
    n_cmp++; if ({to, s, cout, v} !== {1'b0, 16'h8000, 2'b01}) begin
      n_fail++; $display("FAIL ovf_add: got to=%b s=%h c=%b v=%b want to=0 s=8000 c=0 v=1",
                         to, s, cout, v); end
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bc, to);
    n_cmp++; if ({to, s, cout, v} !== {1'b0, 16'h7FFF, 2'b11}) begin
      n_fail++; $display("FAIL ovf_sub: got to=%b s=%h c=%b v=%b want to=0 s=7fff c=1 v=1",
                         to, s, cout, v); end
  endtask

  task automatic test_ripple();
    int lat, bc; logic to;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc, to);
    n_cmp++; if ({to, s, cout, v} !== {1'b0, 16'h0000, 2'b10}) begin
      n_fail++; $display("FAIL ripple: got to=%b s=%h c=%b v=%b want to=0 s=0000 c=1 v=0",
                         to, s, cout, v); end
  endtask

  task automatic test_ignored_start();
    int lat, bc; logic to;
    // run_op leaves start high and swaps operands to 1111/2222 sel=1 after acceptance.
    run_op(16'h0101, 16'h0202, 1'b0, 1'b1, lat, bc, to);
    n_cmp++; if ({to, lat[3:0], s} !== {1'b0, 4'd4, 16'h0303}) begin
      n_fail++; $display("FAIL ign_first: got to=%b lat=%0d s=%h want to=0 lat=4 s=0303",
                         to, lat, s); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_gap: got busy=%b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_restart: got busy=%b want 1", busy); end
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
    end
    // Second op latched 1111 - 2222 (sel was flipped to 1): 0x1111 + 0xDDDD + 1 = 0xEEEF, borrow.
    n_cmp++; if ({to, s, cout} !== {1'b0, 16'hEEEF, 1'b0}) begin
      n_fail++; $display("FAIL ign_second: got to=%b s=%h c=%b want to=0 s=eeef c=0", to, s, cout); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic to;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc, to);  // leaves cout=1
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sel = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);  // now in RUN index 2
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, cout, v, s} !== {4'b0000, 16'h0000}) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b done=%b c=%b v=%b s=%h want all 0",
                         busy, done, cout, v, s); end
    @(negedge clk); rst_n = 1'b1;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat, bc, to);
    n_cmp++; if ({to, s, cout, v} !== {1'b0, 16'h0007, 2'b00}) begin
      n_fail++; $display("FAIL post_reset: got to=%b s=%h c=%b v=%b want to=0 s=0007 c=0 v=0",
                         to, s, cout, v); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_ripple();
    test_ignored_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
